// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame/baud parameters.
// Imported by the rx and tx paths so both agree on frame format and baud rate.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_t;

  localparam int DBIT_DEF     = 8;
  localparam int SB_TICK_DEF  = 16;
  localparam int DVSR_DEF     = 163;
  localparam int DVSR_BIT_DEF = 8;

endpackage

// File: rtl/uart_fifo.sv
// Register-array FIFO with first-word fall-through read data; pushes and pops take effect on the edge.
// A write while full is accepted only when a valid read pops in the same cycle; reads on empty are ignored.
module uart_fifo #(
  parameter int B = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  output logic         empty,
  output logic         full,
  output logic [B-1:0] r_data
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [B-1:0] mem [2**W];
  logic [W-1:0] wr_ptr, rd_ptr;
  logic [W-1:0] wr_succ, rd_succ;
  logic         empty_reg, full_reg;
  logic         rd_en, wr_en;

  assign wr_succ = wr_ptr + ONE;
  assign rd_succ = rd_ptr + ONE;
  assign rd_en   = rd & ~empty_reg;
  assign wr_en   = wr & (~full_reg | rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
    end else begin
      unique case ({wr_en, rd_en})
        2'b01: begin
          rd_ptr   <= rd_succ;
          full_reg <= 1'b0;
          if (rd_succ == wr_ptr) empty_reg <= 1'b1;
        end
        2'b10: begin
          wr_ptr    <= wr_succ;
          empty_reg <= 1'b0;
          if (wr_succ == rd_ptr) full_reg <= 1'b1;
        end
        // Simultaneous push and pop leaves the occupancy, and so both flags, unchanged.
        2'b11: begin
          wr_ptr <= wr_succ;
          rd_ptr <= rd_succ;
        end
        default: ;
      endcase
    end
  end

  assign r_data = mem[rd_ptr];
  assign empty  = empty_reg;
  assign full   = full_reg;

endmodule

// File: rtl/uart_rx_path.sv
// UART receive path: baud tick, 2-flop rx synchroniser, 8N1 deserialiser and byte FIFO; byte lands ~10 bit times after start edge.
// No backpressure toward the line: a byte arriving while the FIFO is full is dropped and overrun_err sticks.
module uart_rx_path import uart_pkg::*; #(
  parameter int DBIT     = DBIT_DEF,
  parameter int SB_TICK  = SB_TICK_DEF,
  parameter int DVSR     = DVSR_DEF,
  parameter int DVSR_BIT = DVSR_BIT_DEF,
  parameter int FIFO_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            rd_uart,
  output logic            rx_empty,
  output logic            rx_full,
  output logic [DBIT-1:0] r_data,
  output logic            frame_err,
  output logic            overrun_err
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

  localparam logic [DVSR_BIT-1:0] DVSR_LAST = DVSR_BIT'(DVSR - 1);
  localparam logic [DVSR_BIT-1:0] BAUD_ONE  = DVSR_BIT'(1);
  localparam logic [SW-1:0]       S_ONE     = SW'(1);
  localparam logic [SW-1:0]       MID_START = SW'(7);
  localparam logic [SW-1:0]       BIT_LAST  = SW'(15);
  localparam logic [SW-1:0]       STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0]       N_ONE     = NW'(1);
  localparam logic [NW-1:0]       N_LAST    = NW'(DBIT - 1);

  logic [DVSR_BIT-1:0] baud_cnt;
  logic                s_tick;
  logic                rx_meta, rx_s;
  rx_state_t           state, state_next;
  logic [SW-1:0]       s_cnt, s_cnt_next;
  logic [NW-1:0]       n, n_next;
  logic [DBIT-1:0]     shift, shift_next;
  logic                rx_done, stop_bad;

  assign s_tick = (baud_cnt == DVSR_LAST);

  always_ff @(posedge clk) begin
    if (reset)       baud_cnt <= '0;
    else if (s_tick) baud_cnt <= '0;
    else             baud_cnt <= baud_cnt + BAUD_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s_cnt <= '0;
      n     <= '0;
      shift <= '0;
    end else begin
      state <= state_next;
      s_cnt <= s_cnt_next;
      n     <= n_next;
      shift <= shift_next;
    end
  end

  always_comb begin
    state_next = state;
    s_cnt_next = s_cnt;
    n_next     = n;
    shift_next = shift;
    rx_done    = 1'b0;
    stop_bad   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_cnt_next = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == MID_START) begin
            // A start bit that is high again at its midpoint was line noise.
            if (!rx_s) begin
              state_next = DATA;
              s_cnt_next = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_cnt_next = s_cnt + S_ONE;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            shift_next = {rx_s, shift[DBIT-1:1]};
            s_cnt_next = '0;
            if (n == N_LAST) state_next = STOP;
            else             n_next     = n + N_ONE;
          end else begin
            s_cnt_next = s_cnt + S_ONE;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == STOP_LAST) begin
            rx_done    = rx_s;
            stop_bad   = ~rx_s;
            state_next = IDLE;
          end else begin
            s_cnt_next = s_cnt + S_ONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (rx_done && rx_full && !rd_uart) overrun_err <= 1'b1;
    end
  end

  uart_fifo #(
    .B (DBIT),
    .W (FIFO_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd_uart),
    .wr     (rx_done),
    .w_data (shift),
    .empty  (rx_empty),
    .full   (rx_full),
    .r_data (r_data)
  );

endmodule

// File: tb/tb_uart_rx_path.sv
// Directed bench for uart_rx_path with a fast baud divider (one bit = 64 clk cycles).
module tb_uart_rx_path;

  localparam int BIT_CYC = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rd_uart = 1'b0;
  logic       rx_empty, rx_full, frame_err, overrun_err;
  logic [7:0] r_data;

  int total = 0;
  int bad   = 0;
  int ferr_cycles = 0;
  int ovr_cycles  = 0;

  always #5 clk = ~clk;

  uart_rx_path #(
    .DBIT     (8),
    .SB_TICK  (16),
    .DVSR     (4),
    .DVSR_BIT (8),
    .FIFO_W   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rd_uart     (rd_uart),
    .rx_empty    (rx_empty),
    .rx_full     (rx_full),
    .r_data      (r_data),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always @(negedge clk) begin
    if (frame_err === 1'b1)   ferr_cycles++;
    if (overrun_err === 1'b1) ovr_cycles++;
  end

  typedef struct {
    logic [7:0] data;
    bit         stop_val;
    int         stop_len;
    bit         exp_push;
    int         exp_ferr;
  } vec_t;

  vec_t       tbl [5];
  logic [7:0] got [$];
  logic [7:0] burst [5];
  int         ferr_base;
  int         ovr_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_val, input int stop_len);
    rx = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(BIT_CYC);
    end
    rx = stop_val;
    wait_cyc(stop_len);
    rx = 1'b1;
  endtask

  task automatic pop;
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'h35, 1'b1, 64, 1'b1, 0};
    tbl[1] = '{8'hA5, 1'b0, 48, 1'b0, 1};
    tbl[2] = '{8'h3C, 1'b1, 64, 1'b1, 0};
    tbl[3] = '{8'h00, 1'b1, 64, 1'b1, 0};
    tbl[4] = '{8'hFF, 1'b1, 64, 1'b1, 0};
    burst  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    do_reset();
    chk("reset_empty", {31'd0, rx_empty}, 32'd1);
    chk("reset_full", {31'd0, rx_full}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    chk("reset_ovr", {31'd0, overrun_err}, 32'd0);

    ferr_base = ferr_cycles;
    ovr_base  = ovr_cycles;
    wait_cyc(2000);
    chk("idle_empty", {31'd0, rx_empty}, 32'd1);
    chk("idle_ferr_cycles", ferr_cycles - ferr_base, 32'd0);
    chk("idle_ovr_cycles", ovr_cycles - ovr_base, 32'd0);

    for (int v = 0; v < 5; v++) begin
      ferr_base = ferr_cycles;
      send_frame(tbl[v].data, tbl[v].stop_val, tbl[v].stop_len);
      wait_cyc(BIT_CYC + 16);
      chk($sformatf("vec%0d_ferr_cycles", v), ferr_cycles - ferr_base, tbl[v].exp_ferr);
      chk($sformatf("vec%0d_empty", v), {31'd0, rx_empty}, {31'd0, ~tbl[v].exp_push});
      chk($sformatf("vec%0d_full", v), {31'd0, rx_full}, 32'd0);
      if (tbl[v].exp_push) begin
        chk($sformatf("vec%0d_rdata", v), {24'd0, r_data}, {24'd0, tbl[v].data});
        pop();
        chk($sformatf("vec%0d_empty_after_pop", v), {31'd0, rx_empty}, 32'd1);
      end
    end
    chk("table_no_overrun", {31'd0, overrun_err}, 32'd0);

    // Back-to-back frames drained by a reader that pops whenever it sees data.
    got.delete();
    fork
      begin
        send_frame(8'h05, 1'b1, BIT_CYC);
        send_frame(8'hFB, 1'b1, BIT_CYC);
        send_frame(8'h20, 1'b1, BIT_CYC);
        wait_cyc(40);
      end
      begin
        for (int c = 0; c < 2000; c++) begin
          @(negedge clk);
          if (!rx_empty) begin
            got.push_back(r_data);
            rd_uart = 1'b1;
          end else begin
            rd_uart = 1'b0;
          end
        end
        rd_uart = 1'b0;
      end
    join
    chk("stream_count", got.size(), 32'd3);
    if (got.size() == 3) begin
      chk("stream_b0", {24'd0, got[0]}, 32'h05);
      chk("stream_b1", {24'd0, got[1]}, 32'hFB);
      chk("stream_b2", {24'd0, got[2]}, 32'h20);
    end
    chk("stream_empty", {31'd0, rx_empty}, 32'd1);

    // Fill past depth with no reads.
    for (int k = 0; k < 5; k++) begin
      send_frame(burst[k], 1'b1, BIT_CYC);
      if (k == 3) begin
        wait_cyc(8);
        chk("fill4_full", {31'd0, rx_full}, 32'd1);
        chk("fill4_no_ovr", {31'd0, overrun_err}, 32'd0);
      end
    end
    wait_cyc(BIT_CYC);
    chk("fill5_ovr", {31'd0, overrun_err}, 32'd1);
    chk("fill5_full", {31'd0, rx_full}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_rdata", k), {24'd0, r_data}, {24'd0, burst[k]});
      pop();
    end
    chk("drain_empty", {31'd0, rx_empty}, 32'd1);
    chk("drain_not_full", {31'd0, rx_full}, 32'd0);
    chk("drain_ovr_sticky", {31'd0, overrun_err}, 32'd1);

    // Short low glitch must not start a frame.
    ferr_base = ferr_cycles;
    rx = 1'b0;
    wait_cyc(12);
    rx = 1'b1;
    wait_cyc(200);
    chk("glitch_empty", {31'd0, rx_empty}, 32'd1);
    chk("glitch_ferr_cycles", ferr_cycles - ferr_base, 32'd0);

    // Reset during data bit 4; the remaining bits of 0xF0 are high so no false start follows.
    fork
      send_frame(8'hF0, 1'b1, BIT_CYC);
      begin
        wait_cyc(BIT_CYC * 5 + 20);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
      end
    join
    ferr_base = ferr_cycles;
    wait_cyc(BIT_CYC + 16);
    chk("midreset_empty", {31'd0, rx_empty}, 32'd1);
    chk("midreset_ovr_cleared", {31'd0, overrun_err}, 32'd0);
    chk("midreset_ferr_cycles", ferr_cycles - ferr_base, 32'd0);
    send_frame(8'h77, 1'b1, BIT_CYC);
    wait_cyc(16);
    chk("after_reset_empty", {31'd0, rx_empty}, 32'd0);
    chk("after_reset_rdata", {24'd0, r_data}, 32'h77);
    pop();
    chk("after_reset_pop_empty", {31'd0, rx_empty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
